// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block constants, FSM encoding, S-box and GF(2^8) helpers.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_NR    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TABLE[2047 - 8 * int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; row 0 sits in bits [31:24].
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the final round), AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] rkey,
  input  logic                 final_round,
  output logic [AES_BLK_W-1:0] state_out
);

  logic [7:0]           sub_s [16];
  logic [AES_BLK_W-1:0] shift_s;
  logic [AES_BLK_W-1:0] mix_s;

  // Byte i of the state is row i%4, column i/4.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign sub_s[i] = sbox(state_in[127-8*i -: 8]);
  end

  // Row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shift_s[127-8*(r+4*c) -: 8] = sub_s[r + 4*((c + r) % 4)];
    end
    assign mix_s[127-32*c -: 32] = mix_column(shift_s[127-32*c -: 32]);
  end

  assign state_out = (final_round ? shift_s : mix_s) ^ rkey;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, valid/ready on both sides,
// and a hold-off counter that keeps plaintext out while new round keys settle.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int KEY_SETTLE = 12,
  parameter int NR         = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_update,
  input  logic [AES_BLK_W-1:0] r0_key,
  input  logic [AES_BLK_W-1:0] r1_key,
  input  logic [AES_BLK_W-1:0] r2_key,
  input  logic [AES_BLK_W-1:0] r3_key,
  input  logic [AES_BLK_W-1:0] r4_key,
  input  logic [AES_BLK_W-1:0] r5_key,
  input  logic [AES_BLK_W-1:0] r6_key,
  input  logic [AES_BLK_W-1:0] r7_key,
  input  logic [AES_BLK_W-1:0] r8_key,
  input  logic [AES_BLK_W-1:0] r9_key,
  input  logic [AES_BLK_W-1:0] r10_key,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy
);

  if (NR != AES_NR) begin : g_bad_nr
    $error("aes_encrypt_iter: only NR=10 (AES-128) is supported");
  end
  if (KEY_SETTLE < 1 || KEY_SETTLE > 255) begin : g_bad_settle
    $error("aes_encrypt_iter: KEY_SETTLE must be in 1..255");
  end

  localparam logic [7:0] SETTLE_INIT = 8'(KEY_SETTLE);

  aes_state_e           state_r;
  logic [3:0]           round_r;
  logic [AES_BLK_W-1:0] blk_r;
  logic [7:0]           settle_r;
  logic                 out_valid_r;
  logic [AES_BLK_W-1:0] out_data_r;
  logic                 busy_r;
  logic [AES_BLK_W-1:0] rkey_s;
  logic [AES_BLK_W-1:0] round_out_s;
  logic                 in_ready_s;
  logic                 final_s;

  assign in_ready_s = (state_r == IDLE) && (settle_r == 8'd0) && !key_update;
  assign final_s    = (round_r == 4'd10);

  // Select the round key for the round currently being applied.
  always_comb begin
    rkey_s = r0_key;
    case (round_r)
      4'd0:    rkey_s = r0_key;
      4'd1:    rkey_s = r1_key;
      4'd2:    rkey_s = r2_key;
      4'd3:    rkey_s = r3_key;
      4'd4:    rkey_s = r4_key;
      4'd5:    rkey_s = r5_key;
      4'd6:    rkey_s = r6_key;
      4'd7:    rkey_s = r7_key;
      4'd8:    rkey_s = r8_key;
      4'd9:    rkey_s = r9_key;
      4'd10:   rkey_s = r10_key;
      default: rkey_s = r0_key;
    endcase
  end

  aes_round u_round (
    .state_in    (blk_r),
    .rkey        (rkey_s),
    .final_round (final_s),
    .state_out   (round_out_s)
  );

  // Key-settle hold-off: reload on every key change, then count down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_r <= SETTLE_INIT;
    end else if (key_update) begin
      settle_r <= SETTLE_INIT;
    end else if (settle_r != 8'd0) begin
      settle_r <= settle_r - 8'd1;
    end
  end

  // Block FSM: accept, iterate ten rounds, hold the result until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      round_r     <= 4'd0;
      blk_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_s) begin
            blk_r   <= in_data ^ r0_key;
            round_r <= 4'd1;
            state_r <= ROUND;
            busy_r  <= 1'b1;
          end
        end
        ROUND: begin
          if (key_update) begin
            // Keys changed under us: drop the block without producing output.
            state_r <= IDLE;
            round_r <= 4'd0;
            busy_r  <= 1'b0;
          end else begin
            blk_r <= round_out_s;
            if (final_s) begin
              out_data_r  <= round_out_s;
              out_valid_r <= 1'b1;
              round_r     <= 4'd0;
              state_r     <= DONE;
            end else begin
              round_r <= round_r + 4'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          round_r     <= 4'd0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter using FIPS-197 and SP800-38A known-answer vectors.
module tb_aes_encrypt_iter;
  import aes_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         key_update;
  logic [127:0] rk [11];
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [127:0] ecb_pt [4];
  logic [127:0] ecb_ct [4];

  aes_encrypt_iter #(.KEY_SETTLE(12), .NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .key_update(key_update),
    .r0_key(rk[0]), .r1_key(rk[1]), .r2_key(rk[2]), .r3_key(rk[3]),
    .r4_key(rk[4]), .r5_key(rk[5]), .r6_key(rk[6]), .r7_key(rk[7]),
    .r8_key(rk[8]), .r9_key(rk[9]), .r10_key(rk[10]),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench-side key schedule supplying the round-key inputs.
  task automatic set_keys(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic pulse_key_update();
    key_update = 1'b1;
    tick();
    key_update = 1'b0;
  endtask

  // Present a block and wait (bounded) until the accepting edge has passed.
  task automatic accept(input string tag, input logic [127:0] pt);
    int n;
    in_valid = 1'b1;
    in_data  = pt;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid and compare the ciphertext.
  task automatic expect_out(input string tag, input logic [127:0] ct);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    check({tag, "_data"}, out_data, ct);
  endtask

  initial begin
    int cnt;
    int n_acc;
    int n_out;
    int cyc;
    int acc_cyc [4];
    logic saw;
    logic took;

    ecb_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    ecb_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    ecb_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    ecb_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    ecb_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    ecb_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    ecb_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
    ecb_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;

    rst_n      = 1'b0;
    key_update = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    set_keys(KEY_B);
    tick();
    tick();

    // Reset values.
    check("rst_in_ready",  {127'd0, in_ready},  128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_data",  out_data,            128'd0);
    check("rst_busy",      {127'd0, busy},      128'd0);

    // Settle hold-off after reset with in_valid already high.
    in_valid = 1'b1;
    in_data  = PT_B;
    rst_n    = 1'b1;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("settle_after_reset", 128'(cnt), 128'd12);

    // key_update coinciding with in_valid wins; counter reloads.
    key_update = 1'b1;
    #1;
    check("kupd_blocks_ready", {127'd0, in_ready}, 128'd0);
    tick();
    key_update = 1'b0;
    check("kupd_no_accept", {127'd0, busy}, 128'd0);
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("settle_reload", 128'(cnt), 128'd12);

    // App. B vector, latency exactly 10 cycles after the accepting edge.
    tick();
    in_valid = 1'b0;
    check("b_busy_after_accept", {127'd0, busy}, 128'd1);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("b_latency", 128'(cnt), 128'd10);
    check("b_data", out_data, CT_B);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b_valid_cleared", {127'd0, out_valid}, 128'd0);
    check("b_idle", {127'd0, busy}, 128'd0);

    // App. C.1 vector, then back-pressure for 5 cycles.
    set_keys(KEY_C);
    pulse_key_update();
    accept("c_accept", PT_C);
    expect_out("c", CT_C);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("c_hold_valid", {127'd0, out_valid}, 128'd1);
      check("c_hold_data",  out_data,            CT_C);
      check("c_hold_ready", {127'd0, in_ready},  128'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Abort on round 5 with key_update.
    set_keys(KEY_B);
    pulse_key_update();
    accept("abort_accept", PT_B);
    for (int i = 0; i < 4; i++) tick();
    key_update = 1'b1;
    tick();
    key_update = 1'b0;
    check("abort_idle", {127'd0, busy}, 128'd0);
    saw = out_valid;
    for (int i = 0; i < 15; i++) begin
      tick();
      saw = saw | out_valid;
    end
    check("abort_no_output", {127'd0, saw}, 128'd0);
    accept("abort_reaccept", PT_B);
    expect_out("abort_b", CT_B);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of round 3.
    set_keys(KEY_C);
    pulse_key_update();
    accept("arst_accept", PT_C);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {127'd0, out_valid}, 128'd0);
    check("arst_out_data",  out_data,            128'd0);
    check("arst_busy",      {127'd0, busy},      128'd0);
    check("arst_in_ready",  {127'd0, in_ready},  128'd0);
    tick();
    rst_n = 1'b1;
    accept("arst_reaccept", PT_C);
    expect_out("arst_c", CT_C);
    out_ready = 1'b1;
    tick();

    // Back-to-back stream of four SP800-38A blocks with out_ready held high.
    set_keys(KEY_B);
    pulse_key_update();
    in_valid = 1'b1;
    in_data  = ecb_pt[0];
    n_acc = 0;
    n_out = 0;
    cyc   = 0;
    while (n_out < 4 && cyc < 300) begin
      took = 1'b0;
      if (in_valid && in_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        took = 1'b1;
      end
      if (out_valid) begin
        check("b2b_data", out_data, ecb_ct[n_out]);
        n_out++;
      end
      tick();
      cyc++;
      if (took) begin
        if (n_acc < 4) in_data = ecb_pt[n_acc];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_out_count", 128'(n_out), 128'd4);
    check("b2b_acc_count", 128'(n_acc), 128'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < n_acc) check("b2b_spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd12);
      else check("b2b_spacing_missing", 128'(n_acc), 128'd4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_iter.md
Name: aes_encrypt_iter

Overview:
- Iterative AES-128 encryption core that sits directly downstream of the key expansion stage.
- Consumes its eleven 128-bit round keys r0_key..r10_key and encrypts one 128-bit block over 10 clock cycles, one round per cycle.
- Valid/ready handshake on both plaintext input and ciphertext output.
- Key-settle hold-off counter keeps blocks out until freshly loaded round keys are stable.

Parameters:
- KEY_SETTLE, 12: cycles in_ready is held low after a key_update pulse; valid range 1..255.
- NR, 10: round count; only 10 (AES-128) is supported, and elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- key_update  input  1  one-cycle pulse: upstream cipher key changed, round keys now settling
- r0_key..r10_key  input  128 each  round keys, word 0 in bits [127:96]
- in_valid  input  1  plaintext valid
- in_ready  output  1  core can accept plaintext
- in_data  input  128  plaintext, byte 0 in bits [127:120]
- out_valid  output  1  ciphertext valid
- out_ready  input  1  consumer accepts ciphertext
- out_data  output  128  ciphertext
- busy  output  1  high in ROUND or DONE

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n); all flops clear on the rst_n falling edge, independent of clk.
- Reset values:
  - state=IDLE, round counter=0, state register=0.
  - settle counter=KEY_SETTLE, so the core waits for keys after reset.
  - in_ready=0, out_valid=0, out_data=0, busy=0.
- Settle counter:
  - Loaded with KEY_SETTLE on any cycle key_update=1, in every state.
  - Otherwise decrements by 1 per cycle while nonzero, saturating at 0.
- in_ready = (state==IDLE) && (settle==0) && !key_update. It is combinational from registers plus key_update.
- States:
  - IDLE: on in_valid && in_ready, latch state_reg = in_data ^ r0_key, set round=1, go to ROUND.
  - ROUND: each cycle, state_reg <= SubBytes, ShiftRows, MixColumns of state_reg, XOR rkey[round]; round increments.
    - When round==10, MixColumns is skipped (final round), the result is written to out_data, out_valid is set, and the state goes to DONE.
    - round selects r1..r10 via an 11:1 mux.
  - DONE: hold out_valid=1 and out_data stable until out_ready=1, then clear out_valid and go to IDLE.
    - The next block can be accepted one cycle after the output handshake at the earliest.
- Latency: accept on edge E; rounds applied on edges E+1..E+10; out_valid=1 after edge E+10. Minimum spacing between accepts is 12 cycles.
- Key stability: r0..r10 must be stable from accept until the round-10 edge. The core samples keys combinationally each round.
- Boundary conditions:
  - key_update in ROUND: abort. Go to IDLE, round=0; out_valid is never asserted for that block and the block is dropped silently.
  - key_update in DONE: the held result is unaffected (it was computed with the old keys). Handshake proceeds normally; the settle counter is reloaded.
  - key_update and in_valid in the same IDLE cycle: key_update wins; no accept.
  - out_ready high while not in DONE: ignored.
  - in_valid while busy: ignored, and the upstream holds it per the handshake.
  - rst_n asserted mid-ROUND: immediate return to the reset values; no output is produced.
- Byte order: state byte i = in_data[127-8i -: 8], column-major per FIPS-197.

Decomposition:
- Shared package aes_pkg:
  - constants AES_BLK_W=128 and AES_NR=10;
  - state enum {IDLE, ROUND, DONE};
  - functions xtime() and mix_column() for GF(2^8) arithmetic.
- One combinational sub-module, aes_round:
  - inputs: state_in[127:0], rkey[127:0], final flag;
  - output: state_out[127:0];
  - contains 16 Sbox instances, the ShiftRows wiring, 4 MixColumns units (bypassed when final=1) and the AddRoundKey XOR.
- The top level holds the FSM, round counter, settle counter, round-key mux and the registers.

Test Plan:
- FIPS-197 App. B vector: key 2b7e151628aed2a6abf7158809cf4f3c, bench-supplied round keys, in_data 3243f6a8885a308d313198a2e0370734 → out_data 3925841d02dc09fbdc118597196a0b32 with out_valid exactly 10 cycles after accept.
- App. C.1 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a. Then hold out_ready=0 for 5 cycles → out_valid and out_data stable; in_ready=0 throughout.
- Reset and settle: after rst_n release with in_valid=1, in_ready stays 0 for exactly KEY_SETTLE cycles, then accepts. Pulse key_update at the same time as in_valid → no accept; the counter reloads to 12.
- Abort: key_update on round 5 → FSM in IDLE next cycle, out_valid never rises. After 12 cycles, re-encrypt the App. B block → correct ciphertext.
- Async reset mid-ROUND: drop rst_n between clock edges at round 3 → all outputs go to 0 immediately, in_ready=0; after release, the App. C.1 block encrypts correctly.
- Back-to-back: in_valid held high with 4 blocks and out_ready=1 → accepts spaced 12 cycles apart, outputs in order, all matching a software model.
